// File: rtl/button_pio_pkg.sv
// Shared definitions for the button PIO servicer: register map, FSM encoding, event entry layout.
// The timestamp field exists only when BUTTON_EVT_TIMESTAMP_EN is defined.
package button_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    // Button count of the PIO this slice is built against; the top's WIDTH must match it.
    localparam int BTN_WIDTH = 3;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_WAIT_IRQ = 3'd1,
        ST_RD_CAP   = 3'd2,
        ST_RD_CAP_W = 3'd3,
        ST_WR_CLR   = 3'd4,
        ST_RD_LVL   = 3'd5,
        ST_RD_LVL_W = 3'd6,
        ST_PUSH     = 3'd7
    } state_t;

    typedef struct packed {
        logic [BTN_WIDTH-1:0] edges;
        logic [BTN_WIDTH-1:0] levels;
`ifdef BUTTON_EVT_TIMESTAMP_EN
        logic [15:0]          timestamp;
`endif
    } evt_t;

endpackage

// File: rtl/button_evt_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry visible the cycle after its push.
// Latency: 1 cycle push-to-visible. Backpressure: push ignored when full unless a pop frees the slot.
// Read data is forced to zero while empty.
module button_evt_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wr_dat,
    input  logic         pop,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          wr_en, rd_en;

    assign full   = (count == (PW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign rd_en  = pop && !empty;
    assign wr_en  = push && (!full || rd_en);
    assign rd_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_dat;
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/button_pio_irq_servicer.sv
// Avalon-MM master owning the button PIO: programs irq_mask, drains edge_capture into an event FIFO.
// Latency: irq seen in WAIT_IRQ -> evt_valid 7 cycles later. Backpressure: evt_ready only stalls pops;
// a full FIFO drops events into overflow_cnt. BUTTON_EVT_TIMESTAMP_EN adds a per-event cycle timestamp.
module button_pio_irq_servicer
    import button_pio_pkg::*;
#(
    parameter int               WIDTH        = BTN_WIDTH,
    parameter int               FIFO_DEPTH   = 4,
    parameter logic [WIDTH-1:0] MASK_DEFAULT = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic             cfg_mask_wr,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    input  logic [31:0]      pio_readdata,
    input  logic             pio_irq,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_levels,
`ifdef BUTTON_EVT_TIMESTAMP_EN
    output logic [15:0]      evt_timestamp,
`endif
    output logic [7:0]       overflow_cnt,
    output logic             busy
);
    state_t           st, st_nxt;
    logic [WIDTH-1:0] mask_q;
    logic             mask_pend;
    logic [WIDTH-1:0] edges_q, levels_q;
    logic             fifo_full, fifo_empty, pop;
    evt_t             wr_evt, rd_evt;
    logic             unused_rd;

    assign unused_rd = ^pio_readdata[31:WIDTH];
    assign busy      = (st != ST_WAIT_IRQ);
    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;

`ifdef BUTTON_EVT_TIMESTAMP_EN
    logic [15:0] ts_cnt, ts_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (st == ST_WAIT_IRQ && st_nxt == ST_RD_CAP) ts_q <= ts_cnt;
        end
    end

    assign evt_timestamp = rd_evt.timestamp;
`endif

    always_comb begin
        st_nxt = st;
        case (st)
            // After reset the bus registers are idle, so INIT holds until its write is on the bus
            ST_INIT:     if (pio_chipselect && !pio_write_n) st_nxt = ST_WAIT_IRQ;
            ST_WAIT_IRQ: if (mask_pend) st_nxt = ST_INIT;
                         else if (pio_irq) st_nxt = ST_RD_CAP;
            ST_RD_CAP:   st_nxt = ST_RD_CAP_W;
            ST_RD_CAP_W: st_nxt = (pio_readdata[WIDTH-1:0] == '0) ? ST_WAIT_IRQ : ST_WR_CLR;
            ST_WR_CLR:   st_nxt = ST_RD_LVL;
            ST_RD_LVL:   st_nxt = ST_RD_LVL_W;
            ST_RD_LVL_W: st_nxt = ST_PUSH;
            ST_PUSH:     st_nxt = ST_WAIT_IRQ;
            default:     st_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) st <= ST_INIT;
        else          st <= st_nxt;
    end

    // Bus strobes are registered from the next state so they line up with the access state itself
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_address    <= PIO_ADDR_DATA;
            pio_writedata  <= '0;
        end else begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_address    <= PIO_ADDR_DATA;
            pio_writedata  <= '0;
            case (st_nxt)
                ST_INIT: begin
                    pio_chipselect <= 1'b1;
                    pio_write_n    <= 1'b0;
                    pio_address    <= PIO_ADDR_MASK;
                    pio_writedata  <= 32'(mask_q);
                end
                ST_RD_CAP: begin
                    pio_chipselect <= 1'b1;
                    pio_address    <= PIO_ADDR_EDGE;
                end
                ST_WR_CLR: begin
                    pio_chipselect <= 1'b1;
                    pio_write_n    <= 1'b0;
                    pio_address    <= PIO_ADDR_EDGE;
                end
                ST_RD_LVL: pio_chipselect <= 1'b1;
                default: ;
            endcase
        end
    end

    // A pulse on the same cycle the pending write is taken re-arms it with the newer value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q    <= MASK_DEFAULT;
            mask_pend <= 1'b0;
        end else if (cfg_mask_wr) begin
            mask_q    <= cfg_mask;
            mask_pend <= 1'b1;
        end else if (st == ST_WAIT_IRQ && mask_pend) begin
            mask_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edges_q      <= '0;
            levels_q     <= '0;
            overflow_cnt <= '0;
        end else begin
            if (st == ST_RD_CAP_W) edges_q  <= pio_readdata[WIDTH-1:0];
            if (st == ST_RD_LVL_W) levels_q <= pio_readdata[WIDTH-1:0];
            if (st == ST_PUSH && fifo_full && !pop && overflow_cnt != 8'hFF)
                overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

    always_comb begin
        wr_evt        = '0;
        wr_evt.edges  = edges_q;
        wr_evt.levels = levels_q;
`ifdef BUTTON_EVT_TIMESTAMP_EN
        wr_evt.timestamp = ts_q;
`endif
    end

    button_evt_fifo #(
        .W     ($bits(evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (st == ST_PUSH),
        .wr_dat  (wr_evt),
        .pop     (pop),
        .rd_dat  (rd_evt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign evt_edges  = rd_evt.edges;
    assign evt_levels = rd_evt.levels;

endmodule

// File: tb/tb_button_pio_irq_servicer.sv
// Directed bench for button_pio_irq_servicer with a behavioural 3-bit PIO slave and bus access log.
module tb_button_pio_irq_servicer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  cfg_mask = '0;
    logic        cfg_mask_wr = 1'b0;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata = '0;
    logic        pio_irq;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [2:0]  evt_edges;
    logic [2:0]  evt_levels;
`ifdef BUTTON_EVT_TIMESTAMP_EN
    logic [15:0] evt_timestamp;
`endif
    logic [7:0]  overflow_cnt;
    logic        busy;

    button_pio_irq_servicer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_mask       (cfg_mask),
        .cfg_mask_wr    (cfg_mask_wr),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pio_irq        (pio_irq),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_edges      (evt_edges),
        .evt_levels     (evt_levels),
`ifdef BUTTON_EVT_TIMESTAMP_EN
        .evt_timestamp  (evt_timestamp),
`endif
        .overflow_cnt   (overflow_cnt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // PIO slave: not reset by the DUT reset, clear beats a coincident new edge
    logic [2:0] mask_reg = '0;
    logic [2:0] edge_reg = '0;
    logic [2:0] edge_inj = '0;
    logic       irq_force = 1'b0;
    logic [2:0] lvl_in = '0;
    int         cyc = 0;

    assign pio_irq = (|(edge_reg & mask_reg)) | irq_force;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pio_chipselect && pio_write_n)
            pio_readdata <= (pio_address == 2'd0) ? {29'd0, lvl_in} :
                            (pio_address == 2'd2) ? {29'd0, mask_reg} :
                            (pio_address == 2'd3) ? {29'd0, edge_reg} : 32'd0;
        if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
            mask_reg <= pio_writedata[2:0];
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
            edge_reg <= '0;
        else
            edge_reg <= edge_reg | edge_inj;
    end

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        int          cyc;
    } acc_t;
    acc_t log_q[$];
    int   lb = 0;

    always @(negedge clk) begin
        acc_t a;
        if (pio_chipselect) begin
            a.wr   = !pio_write_n;
            a.addr = pio_address;
            a.data = pio_write_n ? 32'd0 : pio_writedata;
            a.cyc  = cyc;
            log_q.push_back(a);
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_acc(input string nm, input int k, input logic wr, input logic [1:0] a,
                           input logic [31:0] d);
        if (lb + k < log_q.size())
            chk(nm, {log_q[lb+k].wr, log_q[lb+k].addr, log_q[lb+k].data}, {wr, a, d});
        else begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: access %0d missing, only %0d logged", nm, k, log_q.size() - lb);
        end
    endtask

    task automatic inject(input logic [2:0] e, input logic spur);
        @(negedge clk);
        if (spur) begin
            irq_force = 1'b1;
            @(negedge clk);
            irq_force = 1'b0;
        end else begin
            edge_inj = e;
            @(posedge clk);
            @(negedge clk);
            edge_inj = '0;
        end
    endtask

    task automatic wait_evt(output int lat);
        lat = 0;
        while (evt_valid !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n < 40, 1);
    endtask

    typedef struct {
        logic [2:0] edg;
        logic [2:0] lvl;
        logic       spur;
        logic       exp_evt;
        logic [2:0] exp_e;
        logic [2:0] exp_l;
        int         exp_acc;
    } vec_t;

    initial begin
        vec_t       vecs [5];
        logic [2:0] oe [5];
        logic [2:0] ol [5];
        int         lat;
        int         n;

        vecs[0] = '{edg: 3'd2, lvl: 3'd3, spur: 1'b0, exp_evt: 1'b1, exp_e: 3'd2, exp_l: 3'd3, exp_acc: 3};
        vecs[1] = '{edg: 3'd0, lvl: 3'd5, spur: 1'b1, exp_evt: 1'b0, exp_e: 3'd0, exp_l: 3'd0, exp_acc: 1};
        vecs[2] = '{edg: 3'd5, lvl: 3'd0, spur: 1'b0, exp_evt: 1'b1, exp_e: 3'd5, exp_l: 3'd0, exp_acc: 3};
        vecs[3] = '{edg: 3'd7, lvl: 3'd6, spur: 1'b0, exp_evt: 1'b1, exp_e: 3'd7, exp_l: 3'd6, exp_acc: 3};
        vecs[4] = '{edg: 3'd4, lvl: 3'd1, spur: 1'b0, exp_evt: 1'b1, exp_e: 3'd4, exp_l: 3'd1, exp_acc: 3};
        oe = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd5};
        ol = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs", pio_chipselect, 0);
        chk("rst_wn", pio_write_n, 1);
        chk("rst_addr", pio_address, 0);
        chk("rst_wdata", pio_writedata, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_edges", evt_edges, 0);
        chk("rst_levels", evt_levels, 0);
        chk("rst_ovf", overflow_cnt, 0);
        chk("rst_busy", busy, 1);

        // Start-up mask programming
        lb = log_q.size();
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("init_nacc", log_q.size() - lb, 1);
        chk_acc("init_wr_mask", 0, 1'b1, 2'd2, 32'h7);
        chk("init_pio_mask", mask_reg, 3'h7);
        chk("init_cs_idle", pio_chipselect, 0);
        chk("init_busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            lvl_in = vecs[i].lvl;
            lb = log_q.size();
            inject(vecs[i].edg, vecs[i].spur);
            if (vecs[i].exp_evt) begin
                wait_evt(lat);
                chk($sformatf("vec%0d_latency", i), lat, 7);
                chk($sformatf("vec%0d_edges", i), evt_edges, vecs[i].exp_e);
                chk($sformatf("vec%0d_levels", i), evt_levels, vecs[i].exp_l);
                evt_ready = 1'b1;
                @(negedge clk);
                evt_ready = 1'b0;
            end else begin
                repeat (10) @(negedge clk);
            end
            chk($sformatf("vec%0d_valid_after", i), evt_valid, 0);
            chk($sformatf("vec%0d_busy", i), busy, 0);
            chk($sformatf("vec%0d_nacc", i), log_q.size() - lb, vecs[i].exp_acc);
            chk_acc($sformatf("vec%0d_rd_cap", i), 0, 1'b0, 2'd3, 32'd0);
            if (vecs[i].exp_acc == 3) begin
                chk_acc($sformatf("vec%0d_wr_clr", i), 1, 1'b1, 2'd3, 32'd0);
                chk_acc($sformatf("vec%0d_rd_lvl", i), 2, 1'b0, 2'd0, 32'd0);
            end
        end

        // Five events into a four-entry FIFO with no consumer
        for (int k = 0; k < 5; k++) begin
            lvl_in = ol[k];
            inject(oe[k], 1'b0);
            repeat (2) @(negedge clk);
            wait_idle($sformatf("ovf%0d_idle", k));
        end
        chk("ovf_cnt", overflow_cnt, 1);
        chk("ovf_valid", evt_valid, 1);
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_pop%0d_valid", k), evt_valid, 1);
            chk($sformatf("ovf_pop%0d_edges", k), evt_edges, oe[k]);
            chk($sformatf("ovf_pop%0d_levels", k), evt_levels, ol[k]);
            @(negedge clk);
        end
        evt_ready = 1'b0;
        chk("ovf_drained", evt_valid, 0);

        // Mask request during a service waits for PUSH
        lb = log_q.size();
        lvl_in = 3'd2;
        inject(3'd1, 1'b0);
        @(negedge clk);
        cfg_mask = 3'd5;
        cfg_mask_wr = 1'b1;
        @(negedge clk);
        cfg_mask_wr = 1'b0;
        repeat (15) @(negedge clk);
        chk("mska_nacc", log_q.size() - lb, 4);
        chk_acc("mska_rd_cap", 0, 1'b0, 2'd3, 32'd0);
        chk_acc("mska_wr_clr", 1, 1'b1, 2'd3, 32'd0);
        chk_acc("mska_rd_lvl", 2, 1'b0, 2'd0, 32'd0);
        chk_acc("mska_wr_mask", 3, 1'b1, 2'd2, 32'h5);
        if (log_q.size() >= lb + 4)
            chk("mska_gap", log_q[lb+3].cyc - log_q[lb+2].cyc, 4);
        chk("mska_pio_mask", mask_reg, 3'h5);
        chk("mska_evt_edges", evt_edges, 3'd1);
        chk("mska_evt_levels", evt_levels, 3'd2);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;

        // Back-to-back requests collapse into one write of the later value
        lb = log_q.size();
        inject(3'd1, 1'b0);
        @(negedge clk);
        cfg_mask = 3'd1;
        cfg_mask_wr = 1'b1;
        @(negedge clk);
        cfg_mask = 3'd4;
        @(negedge clk);
        cfg_mask_wr = 1'b0;
        repeat (15) @(negedge clk);
        chk("mskb_nacc", log_q.size() - lb, 4);
        chk_acc("mskb_wr_mask", 3, 1'b1, 2'd2, 32'h4);
        chk("mskb_pio_mask", mask_reg, 3'h4);
        chk("mskb_busy", busy, 0);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;

        // Asynchronous reset in RD_LVL_W
        lvl_in = 3'd6;
        inject(3'd4, 1'b0);
        n = 0;
        while (!(pio_chipselect && pio_write_n && pio_address == 2'd0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("arst_found_rd_lvl", n < 20, 1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_cs", pio_chipselect, 0);
        chk("arst_wn", pio_write_n, 1);
        chk("arst_addr", pio_address, 0);
        chk("arst_busy", busy, 1);
        chk("arst_valid", evt_valid, 0);
        chk("arst_ovf", overflow_cnt, 0);
        repeat (2) @(negedge clk);
        lb = log_q.size();
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("arst_nacc", log_q.size() - lb, 1);
        chk_acc("arst_init_wr", 0, 1'b1, 2'd2, 32'h7);
        chk("arst_pio_mask", mask_reg, 3'h7);
        chk("arst_busy_after", busy, 0);
        chk("arst_no_evt", evt_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
